pci_conf_cyc_req: RTL and testbench

PCI_CONF_CYC_REQ -- requirements
Module: pci_conf_cyc_req

---
 rtl/pci_conf_cyc_req.sv | 168 ++++++++++++++++
 tb/tb_pci_conf_cyc_req.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pci_conf_cyc_req.sv
// PCI configuration-cycle requester: CONFIG_ADDRESS register plus a retrying issue FSM.
// Define PCI_CONF_CYC_TIMEOUT_EN to add a 1024-cycle WAIT watchdog that ends the cycle with an error.
module pci_conf_cyc_req #(
    parameter int RETRY_MAX = 8,
    parameter int RETRY_GAP = 4
) (
    input  logic        wb_clk_in,
    input  logic        reset_in,
    input  logic        cfg_addr_we,
    input  logic [31:0] cfg_addr_wdata,
    output logic [31:0] cfg_addr_rdata,
    input  logic        cfg_data_req,
    input  logic        cfg_data_we,
    input  logic [3:0]  cfg_data_be,
    input  logic [31:0] cfg_data_wdata,
    output logic        cfg_data_ack,
    output logic        cfg_data_err,
    output logic [31:0] cfg_data_rdata,
    output logic [31:0] ccyc_addr,
    output logic        mst_req,
    output logic [3:0]  mst_cmd,
    output logic [3:0]  mst_be,
    output logic [31:0] mst_wdata,
    input  logic        mst_gnt,
    input  logic        mst_done,
    input  logic        mst_retry,
    input  logic        mst_abort,
    input  logic [31:0] mst_rdata
);

    localparam int RW = $clog2(RETRY_MAX + 1);
    localparam int GW = $clog2(RETRY_GAP + 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(RETRY_MAX - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'(RETRY_GAP - 1);
    localparam logic [31:0]   ADDR_MASK  = 32'h80FF_FFFC;
    localparam logic [31:0]   ALL_ONES   = 32'hFFFF_FFFF;
    localparam logic [3:0]    CMD_RD     = 4'hA;
    localparam logic [3:0]    CMD_WR     = 4'hB;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP, S_DONE} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [31:0]     r_cfg_addr;
    logic [3:0]      r_cmd;
    logic [3:0]      r_be;
    logic [31:0]     r_wdata;
    logic [31:0]     r_rdata;
    logic            r_err;
    logic            r_hold;
    logic [RW-1:0]   r_retry_cnt;
    logic [GW-1:0]   r_gap_cnt;

    logic            w_enable;
    logic [7:0]      w_bus;
    logic [13:0]     w_dfr;
    logic            w_sample;
    logic            w_retry_last;
    logic            w_timeout;

    assign w_enable     = r_cfg_addr[31];
    assign w_bus        = r_cfg_addr[23:16];
    assign w_dfr        = r_cfg_addr[15:2];
    assign w_retry_last = (r_retry_cnt == RETRY_LAST);
    // r_hold masks the request during the cycle right after ack/err, when the
    // requester may not yet have dropped cfg_data_req.
    assign w_sample     = (r_state == S_IDLE) && cfg_data_req && !cfg_addr_we && !r_hold;

    assign ccyc_addr = (w_bus == 8'h00) ? {16'h0000, w_dfr, 2'b00}
                                        : {8'h00, w_bus, w_dfr, 2'b01};

    assign cfg_addr_rdata = r_cfg_addr;
    assign cfg_data_rdata = r_rdata;
    assign cfg_data_ack   = (r_state == S_DONE) && !r_err;
    assign cfg_data_err   = (r_state == S_DONE) && r_err;
    assign mst_req        = (r_state == S_ISSUE);
    assign mst_cmd        = r_cmd;
    assign mst_be         = r_be;
    assign mst_wdata      = r_wdata;

`ifdef PCI_CONF_CYC_TIMEOUT_EN
    logic [9:0] r_wd_cnt;

    always_ff @(posedge wb_clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_wd_cnt <= '0;
        end else if (r_state == S_WAIT) begin
            r_wd_cnt <= r_wd_cnt + 10'd1;
        end else begin
            r_wd_cnt <= '0;
        end
    end

    assign w_timeout = (r_state == S_WAIT) && (r_wd_cnt == 10'h3FF);
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        // NOTE: default first so every path assigns w_state_nxt and no latch is inferred.
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_sample) w_state_nxt = w_enable ? S_ISSUE : S_DONE;
            S_ISSUE: if (mst_gnt) w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (mst_done || mst_abort) w_state_nxt = S_DONE;
                else if (mst_retry)        w_state_nxt = w_retry_last ? S_DONE : S_GAP;
                else if (w_timeout)        w_state_nxt = S_DONE;
            end
            S_GAP:   if (r_gap_cnt == GAP_LAST) w_state_nxt = S_ISSUE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_state     <= S_IDLE;
            r_cfg_addr  <= '0;
            r_cmd       <= '0;
            r_be        <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_hold      <= 1'b0;
            r_retry_cnt <= '0;
            r_gap_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= (r_state == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (cfg_addr_we) begin
                        r_cfg_addr <= cfg_addr_wdata & ADDR_MASK;
                    end else if (w_sample) begin
                        if (w_enable) begin
                            r_cmd       <= cfg_data_we ? CMD_WR : CMD_RD;
                            r_be        <= cfg_data_be;
                            r_wdata     <= cfg_data_wdata;
                            r_retry_cnt <= '0;
                        end else begin
                            r_rdata <= ALL_ONES;
                            r_err   <= 1'b0;
                        end
                    end
                end
                S_WAIT: begin
                    if (mst_done) begin
                        r_rdata <= mst_rdata;
                        r_err   <= 1'b0;
                    end else if (mst_abort) begin
                        r_rdata <= ALL_ONES;
                        r_err   <= 1'b0;
                    end else if (mst_retry) begin
                        r_retry_cnt <= r_retry_cnt + 1'b1;
                        r_gap_cnt   <= '0;
                        r_err       <= w_retry_last;
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                    end
                end
                S_GAP:   r_gap_cnt <= r_gap_cnt + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pci_conf_cyc_req.sv
// Directed bench for pci_conf_cyc_req: address formats, read/write, disabled access, retry, abort, reset.
// With PCI_CONF_CYC_TIMEOUT_EN defined it also exercises the WAIT watchdog.
module tb_pci_conf_cyc_req;

    logic        wb_clk_in = 1'b0;
    logic        reset_in;
    logic        cfg_addr_we;
    logic [31:0] cfg_addr_wdata;
    logic [31:0] cfg_addr_rdata;
    logic        cfg_data_req;
    logic        cfg_data_we;
    logic [3:0]  cfg_data_be;
    logic [31:0] cfg_data_wdata;
    logic        cfg_data_ack;
    logic        cfg_data_err;
    logic [31:0] cfg_data_rdata;
    logic [31:0] ccyc_addr;
    logic        mst_req;
    logic [3:0]  mst_cmd;
    logic [3:0]  mst_be;
    logic [31:0] mst_wdata;
    logic        mst_gnt;
    logic        mst_done;
    logic        mst_retry;
    logic        mst_abort;
    logic [31:0] mst_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    int req_hi_cnt = 0;

    pci_conf_cyc_req dut (
        .wb_clk_in      (wb_clk_in),
        .reset_in       (reset_in),
        .cfg_addr_we    (cfg_addr_we),
        .cfg_addr_wdata (cfg_addr_wdata),
        .cfg_addr_rdata (cfg_addr_rdata),
        .cfg_data_req   (cfg_data_req),
        .cfg_data_we    (cfg_data_we),
        .cfg_data_be    (cfg_data_be),
        .cfg_data_wdata (cfg_data_wdata),
        .cfg_data_ack   (cfg_data_ack),
        .cfg_data_err   (cfg_data_err),
        .cfg_data_rdata (cfg_data_rdata),
        .ccyc_addr      (ccyc_addr),
        .mst_req        (mst_req),
        .mst_cmd        (mst_cmd),
        .mst_be         (mst_be),
        .mst_wdata      (mst_wdata),
        .mst_gnt        (mst_gnt),
        .mst_done       (mst_done),
        .mst_retry      (mst_retry),
        .mst_abort      (mst_abort),
        .mst_rdata      (mst_rdata)
    );

    always #5 wb_clk_in = ~wb_clk_in;

    // Counts clock cycles spent in ISSUE, sampled mid-cycle.
    always @(negedge wb_clk_in) if (mst_req) req_hi_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk_in);
        #1;
    endtask

    task automatic write_addr(input logic [31:0] v);
        cfg_addr_we    = 1'b1;
        cfg_addr_wdata = v;
        tick();
        cfg_addr_we    = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (mst_req !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check({tag, " req_seen"}, 32'(mst_req), 32'd1);
    endtask

    task automatic grant();
        mst_gnt = 1'b1;
        tick();
        mst_gnt = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int base;
        int n;
        reset_in       = 1'b1;
        cfg_addr_we    = 1'b0;
        cfg_addr_wdata = '0;
        cfg_data_req   = 1'b0;
        cfg_data_we    = 1'b0;
        cfg_data_be    = '0;
        cfg_data_wdata = '0;
        mst_gnt        = 1'b0;
        mst_done       = 1'b0;
        mst_retry      = 1'b0;
        mst_abort      = 1'b0;
        mst_rdata      = '0;
        #12;
        check("rst cfg_addr_rdata", cfg_addr_rdata, 32'h0);
        check("rst ccyc_addr", ccyc_addr, 32'h0);
        check("rst mst_req", 32'(mst_req), 32'd0);
        check("rst ack", 32'(cfg_data_ack), 32'd0);
        check("rst err", 32'(cfg_data_err), 32'd0);
        check("rst rdata", cfg_data_rdata, 32'h0);
        @(posedge wb_clk_in);
        #1 reset_in = 1'b0;
        tick();

        // Reserved bits read back as zero; non-zero bus gives a type 1 address.
        write_addr(32'hFFFF_FFFF);
        check("mask cfg_addr_rdata", cfg_addr_rdata, 32'h80FF_FFFC);
        check("mask ccyc_addr", ccyc_addr, 32'h00FF_FFFD);

        // Address write and request in the same cycle: the write wins.
        cfg_addr_we    = 1'b1;
        cfg_addr_wdata = 32'h8000_1A08;
        cfg_data_req   = 1'b1;
        cfg_data_we    = 1'b0;
        cfg_data_be    = 4'hF;
        tick();
        cfg_addr_we = 1'b0;
        check("rd addr_we_prio mst_req", 32'(mst_req), 32'd0);
        check("rd cfg_addr_rdata", cfg_addr_rdata, 32'h8000_1A08);
        check("rd ccyc_addr", ccyc_addr, 32'h0000_1A08);
        wait_req("rd");
        check("rd mst_cmd", 32'(mst_cmd), 32'hA);
        check("rd mst_be", 32'(mst_be), 32'hF);
        grant();
        check("rd req_drop", 32'(mst_req), 32'd0);
        mst_done  = 1'b1;
        mst_rdata = 32'h1234_5678;
        tick();
        mst_done = 1'b0;
        check("rd ack", 32'(cfg_data_ack), 32'd1);
        check("rd err", 32'(cfg_data_err), 32'd0);
        check("rd rdata", cfg_data_rdata, 32'h1234_5678);
        cfg_data_req = 1'b0;
        tick();
        check("rd ack_pulse", 32'(cfg_data_ack), 32'd0);

        // Type 1 write; inputs changed after sampling must not matter.
        write_addr(32'h8003_0810);
        check("wr ccyc_addr", ccyc_addr, 32'h0003_0811);
        cfg_data_req   = 1'b1;
        cfg_data_we    = 1'b1;
        cfg_data_be    = 4'h3;
        cfg_data_wdata = 32'hDEAD_BEEF;
        wait_req("wr");
        check("wr mst_cmd", 32'(mst_cmd), 32'hB);
        check("wr mst_be", 32'(mst_be), 32'h3);
        check("wr mst_wdata", mst_wdata, 32'hDEAD_BEEF);
        cfg_data_we    = 1'b0;
        cfg_data_be    = 4'hC;
        cfg_data_wdata = 32'h0;
        grant();
        check("wr held mst_wdata", mst_wdata, 32'hDEAD_BEEF);
        check("wr held mst_cmd", 32'(mst_cmd), 32'hB);
        check("wr held mst_be", 32'(mst_be), 32'h3);
        mst_done  = 1'b1;
        mst_abort = 1'b1;
        mst_retry = 1'b1;
        mst_rdata = 32'hCAFE_F00D;
        tick();
        mst_done  = 1'b0;
        mst_abort = 1'b0;
        mst_retry = 1'b0;
        check("wr prio ack", 32'(cfg_data_ack), 32'd1);
        check("wr prio err", 32'(cfg_data_err), 32'd0);
        check("wr prio rdata", cfg_data_rdata, 32'hCAFE_F00D);
        cfg_data_req = 1'b0;
        tick();

        // Disabled access: immediate ack with all ones, no bus cycle, hold cycle honoured.
        write_addr(32'h0000_1A08);
        base         = req_hi_cnt;
        cfg_data_req = 1'b1;
        cfg_data_we  = 1'b0;
        tick();
        check("dis ack", 32'(cfg_data_ack), 32'd1);
        check("dis rdata", cfg_data_rdata, 32'hFFFF_FFFF);
        tick();
        check("dis ack_pulse", 32'(cfg_data_ack), 32'd0);
        tick();
        check("dis hold ack", 32'(cfg_data_ack), 32'd0);
        check("dis hold err", 32'(cfg_data_err), 32'd0);
        cfg_data_req = 1'b0;
        tick();
        tick();
        check("dis no_issue", 32'(req_hi_cnt - base), 32'd0);

        // Retry on every issue: 8 issues, 4-cycle gaps, then err.
        write_addr(32'h8000_0800);
        base         = req_hi_cnt;
        cfg_data_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_req("retry");
            grant();
            mst_retry = 1'b1;
            tick();
            mst_retry = 1'b0;
            if (i < 7) begin
                n = 0;
                while (mst_req !== 1'b1 && n < 20) begin
                    tick();
                    n++;
                end
                check($sformatf("retry gap %0d", i), 32'(n), 32'd4);
            end else begin
                check("retry err", 32'(cfg_data_err), 32'd1);
                check("retry ack", 32'(cfg_data_ack), 32'd0);
            end
        end
        cfg_data_req = 1'b0;
        tick();
        tick();
        check("retry issues", 32'(req_hi_cnt - base), 32'd8);

        // Abort (with retry, abort wins); address write during WAIT is ignored.
        write_addr(32'h8000_0804);
        cfg_data_req = 1'b1;
        wait_req("abort");
        grant();
        cfg_addr_we    = 1'b1;
        cfg_addr_wdata = 32'h8001_FFFC;
        tick();
        cfg_addr_we = 1'b0;
        check("abort cfg_addr_rdata", cfg_addr_rdata, 32'h8000_0804);
        check("abort ccyc_addr", ccyc_addr, 32'h0000_0804);
        mst_abort = 1'b1;
        mst_retry = 1'b1;
        tick();
        mst_abort = 1'b0;
        mst_retry = 1'b0;
        check("abort ack", 32'(cfg_data_ack), 32'd1);
        check("abort err", 32'(cfg_data_err), 32'd0);
        check("abort rdata", cfg_data_rdata, 32'hFFFF_FFFF);
        cfg_data_req = 1'b0;
        tick();

        // Reset in WAIT clears everything at once and produces no completion.
        write_addr(32'h8003_0810);
        cfg_data_req = 1'b1;
        wait_req("rstw");
        grant();
        #2 reset_in = 1'b1;
        #1;
        check("rstw mst_req", 32'(mst_req), 32'd0);
        check("rstw ack", 32'(cfg_data_ack), 32'd0);
        check("rstw err", 32'(cfg_data_err), 32'd0);
        check("rstw rdata", cfg_data_rdata, 32'h0);
        check("rstw ccyc_addr", ccyc_addr, 32'h0);
        check("rstw cfg_addr_rdata", cfg_addr_rdata, 32'h0);
        check("rstw mst_cmd", 32'(mst_cmd), 32'h0);
        check("rstw mst_wdata", mst_wdata, 32'h0);
        cfg_data_req = 1'b0;
        mst_done     = 1'b1;
        @(posedge wb_clk_in);
        #1 reset_in = 1'b0;
        tick();
        mst_done = 1'b0;
        tick();
        check("rstw post ack_err", 32'(cfg_data_ack | cfg_data_err), 32'd0);
        check("rstw post mst_req", 32'(mst_req), 32'd0);

`ifdef PCI_CONF_CYC_TIMEOUT_EN
        write_addr(32'h8000_0800);
        cfg_data_req = 1'b1;
        wait_req("wdog");
        grant();
        n = 0;
        while (cfg_data_err !== 1'b1 && n < 1100) begin
            tick();
            n++;
        end
        check("wdog cycles", 32'(n), 32'd1024);
        check("wdog ack", 32'(cfg_data_ack), 32'd0);
        cfg_data_req = 1'b0;
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
